// File: rtl/gps_acq_pkg.sv
// Shared definitions for the acquisition search controller: widths, FSM
// encoding, hit-counter saturation value and sweep configuration bundle.
package gps_acq_pkg;

    localparam int unsigned MAG_W  = 20;
    localparam int unsigned THR_W  = 15;
    localparam int unsigned CODE_W = 11;
    localparam int unsigned DOPP_W = 5;
    localparam int unsigned HIT_W  = 3;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SETTLE    = 3'd1;
    localparam logic [2:0] S_DWELL     = 3'd2;
    localparam logic [2:0] S_CHECK     = 3'd3;
    localparam logic [2:0] S_STEP_CODE = 3'd4;
    localparam logic [2:0] S_STEP_DOPP = 3'd5;
    localparam logic [2:0] S_LOCKED    = 3'd6;
    localparam logic [2:0] S_FAIL      = 3'd7;

    // Hit counter saturates here rather than wrapping.
    localparam logic [HIT_W-1:0] HIT_MAX = '1;

    // Sweep configuration captured when a sweep starts.
    typedef struct packed {
        logic [CODE_W-1:0] code_last;
        logic [DOPP_W-1:0] dopp_last;
        logic [HIT_W-1:0]  need;
    } sweep_cfg_t;

    // Convert raw bin counts / confirm count into last indices, treating 0 as 1.
    function automatic sweep_cfg_t make_cfg(input logic [CODE_W-1:0] code_bins,
                                            input logic [DOPP_W-1:0] dopp_bins,
                                            input logic [HIT_W-1:0]  confirm_need);
        sweep_cfg_t c;
        c.code_last = (code_bins == '0) ? '0 : code_bins - CODE_W'(1);
        c.dopp_last = (dopp_bins == '0) ? '0 : dopp_bins - DOPP_W'(1);
        c.need      = (confirm_need == '0) ? HIT_W'(1) : confirm_need;
        return c;
    endfunction

endpackage

// File: rtl/acq_peak_hold.sv
// Tracks the largest integrated magnitude seen in a sweep and the bin it
// was found in. Ties keep the earlier bin.
module acq_peak_hold
    import gps_acq_pkg::*;
(
    input  logic              mclk,
    input  logic              res,
    input  logic              clear,
    input  logic              sample,
    input  logic [MAG_W-1:0]  mag,
    input  logic [CODE_W-1:0] code_bin,
    input  logic [DOPP_W-1:0] dopp_bin,
    output logic [MAG_W-1:0]  peak_mag,
    output logic [CODE_W-1:0] peak_code,
    output logic [DOPP_W-1:0] peak_dopp
);

    // Peak register: cleared at sweep start, strict-greater update on sample.
    always_ff @(posedge mclk or posedge res) begin
        if (res) begin
            peak_mag  <= '0;
            peak_code <= '0;
            peak_dopp <= '0;
        end else if (clear) begin
            peak_mag  <= '0;
            peak_code <= '0;
            peak_dopp <= '0;
        end else if (sample && (mag > peak_mag)) begin
            peak_mag  <= mag;
            peak_code <= code_bin;
            peak_dopp <= dopp_bin;
        end
    end

endmodule

// File: rtl/acq_search_ctrl.sv
// Acquisition search sweep controller: steps code/Doppler bins, dwells on
// each, confirms detections and reports lock or failure.
// Optional feature macro: ACQ_PEAKHOLD_EN adds peak magnitude tracking.
module acq_search_ctrl
    import gps_acq_pkg::*;
(
    input  logic              mclk,
    input  logic              res,
    input  logic              start,
    input  logic              abort,
    input  logic              dump_tick,
    input  logic [MAG_W-1:0]  mag,
    input  logic [THR_W-1:0]  thresh,
    input  logic [CODE_W-1:0] code_bins,
    input  logic [DOPP_W-1:0] dopp_bins,
    input  logic [HIT_W-1:0]  confirm_need,
    output logic              aen,
    output logic              code_slew,
    output logic              car_change,
    output logic [CODE_W-1:0] code_bin,
    output logic [DOPP_W-1:0] dopp_bin,
    output logic              busy,
    output logic              locked,
    output logic              fail
`ifdef ACQ_PEAKHOLD_EN
    ,
    output logic [MAG_W-1:0]  peak_mag,
    output logic [CODE_W-1:0] peak_code,
    output logic [DOPP_W-1:0] peak_dopp
`endif
);

    logic [2:0]        state, state_d;
    logic [CODE_W-1:0] code_bin_d;
    logic [DOPP_W-1:0] dopp_bin_d;
    logic [HIT_W-1:0]  hit_cnt, hit_cnt_d;
    logic [MAG_W-1:0]  mag_reg, mag_reg_d;
    sweep_cfg_t        cfg, cfg_d;
    logic              sweep_start;
    logic              hit;
    logic              hit_done;

    // A new sweep may only begin from a resting state; abort overrides it.
    assign sweep_start = start && !abort &&
                         ((state == S_IDLE) || (state == S_LOCKED) || (state == S_FAIL));
    assign hit      = mag_reg > MAG_W'(thresh);
    assign hit_done = ((HIT_W+1)'(hit_cnt) + (HIT_W+1)'(1)) >= (HIT_W+1)'(cfg.need);

    // Threshold-stage latch strobe coincides with the accepted dwell dump.
    assign aen = (state == S_DWELL) && dump_tick && !abort;

    // Next-state and datapath update.
    always_comb begin
        state_d    = state;
        code_bin_d = code_bin;
        dopp_bin_d = dopp_bin;
        hit_cnt_d  = hit_cnt;
        mag_reg_d  = mag_reg;
        cfg_d      = cfg;
        if (abort) begin
            state_d = S_IDLE;
        end else if (sweep_start) begin
            state_d    = S_SETTLE;
            code_bin_d = '0;
            dopp_bin_d = '0;
            hit_cnt_d  = '0;
            cfg_d      = make_cfg(code_bins, dopp_bins, confirm_need);
        end else begin
            case (state)
                S_SETTLE: if (dump_tick) state_d = S_DWELL;
                S_DWELL: begin
                    if (dump_tick) begin
                        mag_reg_d = mag;
                        state_d   = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (hit && hit_done) begin
                        state_d = S_LOCKED;
                    end else if (hit) begin
                        hit_cnt_d = (hit_cnt == HIT_MAX) ? hit_cnt : hit_cnt + HIT_W'(1);
                        state_d   = S_DWELL;
                    end else begin
                        hit_cnt_d = '0;
                        state_d   = S_STEP_CODE;
                    end
                end
                S_STEP_CODE: begin
                    if (code_bin == cfg.code_last) begin
                        code_bin_d = '0;
                        state_d    = S_STEP_DOPP;
                    end else begin
                        code_bin_d = code_bin + CODE_W'(1);
                        state_d    = S_SETTLE;
                    end
                end
                S_STEP_DOPP: begin
                    if (dopp_bin == cfg.dopp_last) begin
                        state_d = S_FAIL;
                    end else begin
                        dopp_bin_d = dopp_bin + DOPP_W'(1);
                        state_d    = S_SETTLE;
                    end
                end
                default: state_d = state;
            endcase
        end
    end

    // State, datapath and registered status/strobe outputs.
    always_ff @(posedge mclk or posedge res) begin
        if (res) begin
            state      <= S_IDLE;
            code_bin   <= '0;
            dopp_bin   <= '0;
            hit_cnt    <= '0;
            mag_reg    <= '0;
            cfg        <= '0;
            code_slew  <= 1'b0;
            car_change <= 1'b0;
            busy       <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state      <= state_d;
            code_bin   <= code_bin_d;
            dopp_bin   <= dopp_bin_d;
            hit_cnt    <= hit_cnt_d;
            mag_reg    <= mag_reg_d;
            cfg        <= cfg_d;
            code_slew  <= (state_d == S_STEP_CODE);
            car_change <= (state_d == S_STEP_DOPP) && (dopp_bin_d != cfg_d.dopp_last);
            busy       <= !((state_d == S_IDLE) || (state_d == S_LOCKED) || (state_d == S_FAIL));
            locked     <= (state_d == S_LOCKED);
            fail       <= (state_d == S_FAIL);
        end
    end

`ifdef ACQ_PEAKHOLD_EN
    // Peak magnitude tracker over every CHECK cycle of the sweep.
    acq_peak_hold u_peak (
        .mclk      (mclk),
        .res       (res),
        .clear     (sweep_start),
        .sample    ((state == S_CHECK) && !abort),
        .mag       (mag_reg),
        .code_bin  (code_bin),
        .dopp_bin  (dopp_bin),
        .peak_mag  (peak_mag),
        .peak_code (peak_code),
        .peak_dopp (peak_dopp)
    );
`endif

endmodule

// File: tb/tb_acq_search_ctrl.sv
// Self-checking bench for acq_search_ctrl: directed table of sweeps,
// hand-written corner sequences and randomized sweeps against a
// dump-by-dump sweep model.
module tb_acq_search_ctrl;

    logic        mclk = 1'b0;
    logic        res = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        dump_tick = 1'b0;
    logic [19:0] mag = '0;
    logic [14:0] thresh = '0;
    logic [10:0] code_bins = '0;
    logic [4:0]  dopp_bins = '0;
    logic [2:0]  confirm_need = '0;
    logic        aen, code_slew, car_change, busy, locked, fail;
    logic [10:0] code_bin;
    logic [4:0]  dopp_bin;
`ifdef ACQ_PEAKHOLD_EN
    logic [19:0] peak_mag;
    logic [10:0] peak_code;
    logic [4:0]  peak_dopp;
`endif

    acq_search_ctrl dut (
        .mclk(mclk), .res(res), .start(start), .abort(abort), .dump_tick(dump_tick),
        .mag(mag), .thresh(thresh), .code_bins(code_bins), .dopp_bins(dopp_bins),
        .confirm_need(confirm_need), .aen(aen), .code_slew(code_slew),
        .car_change(car_change), .code_bin(code_bin), .dopp_bin(dopp_bin),
        .busy(busy), .locked(locked), .fail(fail)
`ifdef ACQ_PEAKHOLD_EN
        , .peak_mag(peak_mag), .peak_code(peak_code), .peak_dopp(peak_dopp)
`endif
    );

    always #5 mclk = ~mclk;

    int checks = 0;
    int errors = 0;
    int n_slew = 0, n_car = 0, n_aen = 0, n_bad_aen = 0;

    // Strobe counters, sampled mid-cycle.
    always @(negedge mclk) begin
        if (code_slew) n_slew++;
        if (car_change) n_car++;
        if (aen) n_aen++;
        if (aen && !dump_tick) n_bad_aen++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Directed magnitude map: two special bins, everything else base.
    int dir_hc, dir_hd, dir_hmag, dir_hc2, dir_hd2, dir_hmag2, dir_base;

    function automatic int dir_mag(input int c, input int d);
        if (c == dir_hc && d == dir_hd) return dir_hmag;
        if (c == dir_hc2 && d == dir_hd2) return dir_hmag2;
        return dir_base;
    endfunction

    function automatic int pick_mag(input int thr);
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 3) return thr + 1 + int'($urandom_range(0, 100));
        if (r < 5) return thr;
        return thr - int'($urandom_range(0, thr));
    endfunction

    task automatic send_dump(input int m);
        @(posedge mclk); #1;
        dump_tick = 1'b1;
        mag = 20'(m);
        @(posedge mclk); #1;
        dump_tick = 1'b0;
        mag = 20'($urandom);
        repeat (5) @(posedge mclk);
        #1;
    endtask

    task automatic start_sweep(input int cb, input int db, input int need, input int thr);
        @(posedge mclk); #1;
        thresh = 15'(thr);
        code_bins = 11'(cb);
        dopp_bins = 5'(db);
        confirm_need = 3'(need);
        start = 1'b1;
        @(posedge mclk); #1;
        start = 1'b0;
        code_bins = 11'($urandom);
        dopp_bins = 5'($urandom);
        confirm_need = 3'($urandom);
    endtask

    // Model results and observed strobe counts of the last sweep.
    int m_lock, m_fail, m_code, m_dopp, m_slew, m_car, m_aen;
    int a_slew, a_car, a_aen;

    // Runs one full sweep; the model walks bins one dump at a time.
    task automatic sweep(input int cb, input int db, input int need, input int thr, input bit rnd);
        int nc, nd, nn, mc, md, hits, s0, c0, a0, m;
        bit settle, done;
        nc = (cb == 0) ? 1 : cb;
        nd = (db == 0) ? 1 : db;
        nn = (need == 0) ? 1 : need;
        s0 = n_slew; c0 = n_car; a0 = n_aen;
        m_lock = 0; m_fail = 0; m_slew = 0; m_car = 0; m_aen = 0;
        mc = 0; md = 0; hits = 0; settle = 1'b1; done = 1'b0;
        start_sweep(cb, db, need, thr);
        for (int k = 0; k < 3000 && !done; k++) begin
            m = rnd ? pick_mag(thr) : dir_mag(mc, md);
            send_dump(m);
            if (settle) begin
                settle = 1'b0;
            end else begin
                m_aen++;
                if (m > thr) begin
                    hits++;
                    if (hits >= nn) begin
                        done = 1'b1;
                        m_lock = 1;
                    end
                end else begin
                    hits = 0;
                    m_slew++;
                    settle = 1'b1;
                    if (mc == nc - 1) begin
                        mc = 0;
                        if (md == nd - 1) begin
                            done = 1'b1;
                            m_fail = 1;
                        end else begin
                            md++;
                            m_car++;
                        end
                    end else begin
                        mc++;
                    end
                end
            end
        end
        check("sweep_terminated", int'(done), 1);
        m_code = mc; m_dopp = md;
        a_slew = n_slew - s0; a_car = n_car - c0; a_aen = n_aen - a0;
    endtask

    typedef struct {
        int cb, db, need, thr, hc, hd, hmag, base;
        int e_lock, e_fail, e_code, e_dopp, e_slew, e_car, e_aen;
    } vec_t;

    vec_t vecs[6];
    int s0, a0;

    initial begin
        // Reset state, including async assertion before any clock edge.
        #3;
        check("rst_busy", int'(busy), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_fail", int'(fail), 0);
        check("rst_strobes", int'({aen, code_slew, car_change}), 0);
        check("rst_bins", int'({code_bin, dopp_bin}), 0);
        repeat (3) @(posedge mclk);
        #1 res = 1'b0;

        // Directed sweep table.
        vecs[0] = '{4, 2, 2, 1000, -1, -1, 0, 500,   0, 1, 0, 1, 8, 1, 8};
        vecs[1] = '{4, 2, 2, 1000, 2, 0, 1500, 500,  1, 0, 2, 0, 2, 0, 4};
        vecs[2] = '{2, 1, 1, 1000, -1, -1, 0, 1000,  0, 1, 0, 0, 2, 0, 2};
        vecs[3] = '{0, 0, 0, 10, -1, -1, 0, 20,      1, 0, 0, 0, 0, 0, 1};
        vecs[4] = '{0, 0, 0, 10, -1, -1, 0, 5,       0, 1, 0, 0, 1, 0, 1};
        vecs[5] = '{3, 3, 1, 200, 1, 2, 201, 200,    1, 0, 1, 2, 7, 2, 8};
        for (int i = 0; i < 6; i++) begin
            dir_hc = vecs[i].hc; dir_hd = vecs[i].hd; dir_hmag = vecs[i].hmag;
            dir_hc2 = -1; dir_hd2 = -1; dir_hmag2 = 0; dir_base = vecs[i].base;
            sweep(vecs[i].cb, vecs[i].db, vecs[i].need, vecs[i].thr, 1'b0);
            check($sformatf("row%0d_locked", i), int'(locked), vecs[i].e_lock);
            check($sformatf("row%0d_fail", i), int'(fail), vecs[i].e_fail);
            check($sformatf("row%0d_code_bin", i), int'(code_bin), vecs[i].e_code);
            check($sformatf("row%0d_dopp_bin", i), int'(dopp_bin), vecs[i].e_dopp);
            check($sformatf("row%0d_slews", i), a_slew, vecs[i].e_slew);
            check($sformatf("row%0d_car", i), a_car, vecs[i].e_car);
            check($sformatf("row%0d_aen", i), a_aen, vecs[i].e_aen);
            check($sformatf("row%0d_busy", i), int'(busy), 0);
        end

        // Hit then miss clears the hit count; start while busy is ignored.
        start_sweep(4, 1, 3, 1000);
        s0 = n_slew;
        send_dump(0);
        send_dump(1500);
        send_dump(500);
        check("hm_code_bin", int'(code_bin), 1);
        check("hm_slew", n_slew - s0, 1);
        @(posedge mclk); #1;
        start = 1'b1; code_bins = 11'd7;
        @(posedge mclk); #1;
        start = 1'b0;
        check("busy_start_ignored", int'(code_bin), 1);
        check("busy_still", int'(busy), 1);
        send_dump(0);
        send_dump(1500);
        send_dump(1500);
        check("hm_not_locked_2", int'(locked), 0);
        send_dump(1500);
        check("hm_locked_3", int'(locked), 1);
        check("hm_lock_code", int'(code_bin), 1);

        // dump_tick in CHECK / STEP_CODE is ignored.
        start_sweep(2, 1, 1, 1000);
        send_dump(0);
        @(posedge mclk); #1;
        dump_tick = 1'b1; mag = 20'd500;
        @(posedge mclk); #1;
        mag = 20'd5000;
        @(posedge mclk); #1;
        @(posedge mclk); #1;
        dump_tick = 1'b0;
        repeat (4) @(posedge mclk);
        #1;
        check("ign_code_bin", int'(code_bin), 1);
        check("ign_locked", int'(locked), 0);
        a0 = n_aen;
        send_dump(0);
        check("ign_settle_aen", n_aen - a0, 0);
        check("ign_not_fail", int'(fail), 0);
        send_dump(5000);
        check("ign_lock", int'(locked), 1);
        check("ign_lock_code", int'(code_bin), 1);

        // Abort in DWELL with a simultaneous dump_tick.
        start_sweep(4, 1, 1, 1000);
        send_dump(0);
        send_dump(500);
        send_dump(0);
        s0 = n_slew;
        @(posedge mclk); #1;
        dump_tick = 1'b1; abort = 1'b1; mag = 20'd5000;
        @(negedge mclk);
        check("abort_aen", int'(aen), 0);
        @(posedge mclk); #1;
        dump_tick = 1'b0; abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_flags", int'({locked, fail}), 0);
        check("abort_code_kept", int'(code_bin), 1);
        repeat (4) @(posedge mclk);
        #1;
        check("abort_no_slew", n_slew - s0, 0);
        @(posedge mclk); #1;
        start = 1'b1; abort = 1'b1; code_bins = 11'd4;
        @(posedge mclk); #1;
        start = 1'b0; abort = 1'b0;
        check("abort_beats_start", int'(busy), 0);
        check("abort_start_code_kept", int'(code_bin), 1);

        // Reset mid-sweep.
        start_sweep(4, 2, 1, 1000);
        send_dump(0);
        send_dump(500);
        check("mid_code_bin", int'(code_bin), 1);
        @(posedge mclk); #2;
        res = 1'b1;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_code", int'(code_bin), 0);
        @(posedge mclk); #1;
        res = 1'b0;
        s0 = n_slew; a0 = n_aen;
        send_dump(5000);
        send_dump(5000);
        check("post_rst_strobes", (n_slew - s0) + (n_aen - a0), 0);
        check("post_rst_idle", int'({busy, locked, fail}), 0);

        // Randomized sweeps against the model.
        for (int i = 0; i < 30; i++) begin
            sweep(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 4)), int'($urandom_range(0, 32767)), 1'b1);
            check($sformatf("rnd%0d_locked", i), int'(locked), m_lock);
            check($sformatf("rnd%0d_fail", i), int'(fail), m_fail);
            check($sformatf("rnd%0d_code", i), int'(code_bin), m_code);
            check($sformatf("rnd%0d_dopp", i), int'(dopp_bin), m_dopp);
            check($sformatf("rnd%0d_slew", i), a_slew, m_slew);
            check($sformatf("rnd%0d_car", i), a_car, m_car);
            check($sformatf("rnd%0d_aen", i), a_aen, m_aen);
        end

`ifdef ACQ_PEAKHOLD_EN
        // Peak hold over a failing sweep.
        dir_hc = 1; dir_hd = 0; dir_hmag = 700;
        dir_hc2 = 3; dir_hd2 = 1; dir_hmag2 = 900; dir_base = 500;
        sweep(4, 2, 2, 1000, 1'b0);
        check("peak_fail", int'(fail), 1);
        check("peak_mag", int'(peak_mag), 900);
        check("peak_code", int'(peak_code), 3);
        check("peak_dopp", int'(peak_dopp), 1);
`endif

        check("aen_only_with_dump", n_bad_aen, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acq_search_ctrl.md
ACQ_SEARCH_CTRL -- requirements
Module: acq_search_ctrl

Interface
REQ-001 SHALL have port mclk, input, 1, single clock; all flops rise on posedge mclk.
REQ-002 SHALL have port res, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have port start, input, 1, one-cycle pulse that begins a search sweep.
REQ-004 SHALL have port abort, input, 1, level; forces return to IDLE.
REQ-005 SHALL have port dump_tick, input, 1, one-cycle end-of-integration strobe from the accumulators.
REQ-006 SHALL have port mag, input, 20, unsigned integrated magnitude, valid in the cycle dump_tick is high.
REQ-007 SHALL have port thresh, input, 15, unsigned detection threshold, zero-extended to 20 bits for the compare.
REQ-008 SHALL have port code_bins, input, 11, half-chip code bins per Doppler bin; 0 treated as 1.
REQ-009 SHALL have port dopp_bins, input, 5, Doppler bins per sweep; 0 treated as 1.
REQ-010 SHALL have port confirm_need, input, 3, consecutive hits required to lock; 0 treated as 1.
REQ-011 SHALL have outputs aen (1, latch strobe to the threshold stage), code_slew (1, half-chip slew pulse), car_change (1, Doppler-step pulse), code_bin (11), dopp_bin (5), busy, locked, fail (1 each).

Function
REQ-012 SHALL implement states IDLE, SETTLE, DWELL, CHECK, STEP_CODE, STEP_DOPP, LOCKED, FAIL.
REQ-013 IDLE: on start, clear code_bin, dopp_bin and hit_cnt, then go to SETTLE; busy=0.
REQ-014 SETTLE: discard exactly one dump_tick, then go to DWELL; aen stays 0.
REQ-015 DWELL: on dump_tick, register mag, assert aen for that same cycle, and go to CHECK next cycle.
REQ-016 CHECK: a hit is mag_reg > thresh, strictly; a value equal to thresh is a miss.
REQ-017 On a hit, hit_cnt+1 >= confirm_need SHALL go to LOCKED; otherwise increment hit_cnt and go to DWELL at the same bin.
REQ-018 On a miss, clear hit_cnt and go to STEP_CODE.
REQ-019 STEP_CODE: pulse code_slew for one cycle.
REQ-020 STEP_CODE, not the last code bin: increment code_bin, then go to SETTLE.
REQ-021 STEP_CODE, code_bin == code_bins-1: wrap code_bin to 0, then go to STEP_DOPP.
REQ-022 STEP_DOPP: pulse car_change for one cycle.
REQ-023 STEP_DOPP, not the last Doppler bin: increment dopp_bin, then go to SETTLE.
REQ-024 STEP_DOPP, dopp_bin == dopp_bins-1: go to FAIL without incrementing dopp_bin.
REQ-025 LOCKED and FAIL SHALL hold their flag and frozen bin indices until start (restart sweep) or abort (go to IDLE).
REQ-026 busy=1 in every state except IDLE, LOCKED and FAIL.
REQ-027 start while busy SHALL be ignored.
REQ-028 abort SHALL win over start and dump_tick in the same cycle; the next state is IDLE, strobes are 0 and indices are retained.
REQ-029 A dump_tick arriving in CHECK, STEP_CODE or STEP_DOPP SHALL be ignored.
REQ-030 code_bins, dopp_bins and confirm_need SHALL be sampled on start and held for the whole sweep.

Reset
REQ-031 res high SHALL asynchronously force IDLE.
REQ-032 res high SHALL clear all counters, indices, mag_reg and peak registers.
REQ-033 res high SHALL drive aen, code_slew, car_change, busy, locked and fail to 0.
REQ-034 Reset mid-sweep SHALL cancel the sweep with no strobe emitted on release.

Configuration
REQ-035 With ACQ_PEAKHOLD_EN defined, the block SHALL track the maximum mag over all CHECK cycles of the sweep, with its code_bin and dopp_bin.
REQ-036 With ACQ_PEAKHOLD_EN defined, the block SHALL output peak_mag[19:0], peak_code[10:0] and peak_dopp[4:0], frozen on LOCKED/FAIL and cleared on start; ties keep the earlier bin.
REQ-037 Without ACQ_PEAKHOLD_EN, those ports and registers SHALL be absent.

Structure
REQ-038 The shared package gps_acq_pkg SHALL hold the state encoding, the widths MAG_W=20, THR_W=15, CODE_W=11 and DOPP_W=5, and the saturation constants.
REQ-039 The peak tracker SHALL be the sub-module acq_peak_hold, instantiated only under ACQ_PEAKHOLD_EN.

Verification
REQ-040 code_bins=4, dopp_bins=2, confirm_need=2, thresh=1000, mag=500 always -> 8 code_slew pulses, 1 car_change pulse, then fail=1 with dopp_bin=1.
REQ-041 mag=1500 at code_bin=2, dopp_bin=0, confirm_need=2 -> locked after the second consecutive hit, code_bin=2, no further code_slew.
REQ-042 mag=1000 equal to thresh=1000 -> treated as a miss, code_slew pulses.
REQ-043 Hit followed by miss with confirm_need=3 -> hit_cnt cleared, step to the next code bin.
REQ-044 abort during DWELL with simultaneous dump_tick -> IDLE next cycle, aen=0.
REQ-045 ACQ_PEAKHOLD_EN defined, peaks 700 at (1,0) and 900 at (3,1), no lock -> peak_mag=900, peak_code=3, peak_dopp=1 at fail.
